// File: rtl/regfile_write_arbiter_pkg.sv
// rf_defs: shared register-file constants for the write-port arbiter.
package rf_defs;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i, ascending with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);
    logic found;
    int   j;
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_i[IW'(j)]) begin
                found = 1'b1;
                idx_o = IW'(j);
            end
        end
        gnt_o = (found && en_i) ? NUM_REQ'(1) << idx_o : '0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port
// behind a one-entry output stage, with pending-write mask and conflict counter.
module regfile_write_arbiter
    import rf_defs::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit DISCARD_R0 = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            port_stall,
    output logic                            wr_en,
    output logic [REG_ADDR_W-1:0]           wr_sel,
    output logic [DATA_WIDTH-1:0]           wr_data,
    output logic [NUM_REGS-1:0]             pending_mask,
    output logic [15:0]                     conflict_cnt
);
    localparam int IW = $clog2(NUM_REQ);

    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  can_accept, xfer, discard;
    logic [IW-1:0]         win;
    logic [REG_ADDR_W-1:0] win_addr;

    assign can_accept = !out_valid_q || !port_stall;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (can_accept && !reset),
        .gnt_o (req_ready),
        .idx_o (win)
    );

    assign win_addr = req_addr[int'(win)*REG_ADDR_W +: REG_ADDR_W];
    assign xfer     = |(req_valid & req_ready);
    // R0 writes complete the handshake but leave the stage empty
    assign discard  = DISCARD_R0 && (win_addr == REG_ZERO);

    always_comb begin
        out_valid_d = xfer ? !discard : (out_valid_q && port_stall);
        sel_d       = xfer ? win_addr : sel_q;
        data_d      = xfer ? req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH] : data_q;
        ptr_d       = xfer ? ((win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1) : ptr_q;
        cnt_d       = ($countones(req_valid) > 1 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sel_q       <= '0;
            data_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wr_en        = out_valid_q && !port_stall;
    assign wr_sel       = sel_q;
    assign wr_data      = data_q;
    assign pending_mask = out_valid_q ? NUM_REGS'(1) << sel_q : '0;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a queue scoreboard checked
// by an independent write-port monitor.
module tb_regfile_write_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*5-1:0]  req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            port_stall = 1'b0;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [4:0]      wr_sel;
    logic [DW-1:0]   wr_data;
    logic [31:0]     pending_mask;
    logic [15:0]     conflict_cnt;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DISCARD_R0(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .port_stall   (port_stall),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .pending_mask (pending_mask),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]         = v;
        req_addr[i*5 +: 5]   = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back(wr_t'{sel: a, data: d});
    endtask

    // Every issued write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: wr_sel=%0d wr_data=%h, none expected", wr_sel, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_sel", 32'(wr_sel), 32'(mon_e.sel));
                chk("wr_data", wr_data, mon_e.data);
                chk("pending_mask", pending_mask, 32'(1) << mon_e.sel);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(k + 1), 32'h100 + k);
        step();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
        req_valid = '0;
        #1;
        chk("reset_wr_en", 32'(wr_en), 32'h0);
        chk("reset_pending", pending_mask, 32'h0);
        chk("reset_cnt", 32'(conflict_cnt), 32'h0);

        // single requester
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        chk("single_ready", 32'(req_ready), 32'b010);
        push(5'd7, 32'hDEADBEEF);
        step();
        req_valid = '0;
        #1;
        chk("single_wr_en", 32'(wr_en), 32'h1);
        chk("single_pending", pending_mask, 32'h80);

        // R0 discard, overlapping the drain of the previous write
        set_req(2, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        chk("r0_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        #1;
        chk("r0_wr_en", 32'(wr_en), 32'h0);
        chk("r0_pending", pending_mask, 32'h0);
        step();
        chk("r0_wr_en_later", 32'(wr_en), 32'h0);

        // round robin from pointer 0
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(k + 1), 32'h100 + k);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1) << (k % 3));
            chk($sformatf("rr_cnt_%0d", k), 32'(conflict_cnt), 32'(k));
            push(5'((k % 3) + 1), 32'h100 + 32'(k % 3));
            step();
        end
        req_valid = '0;
        #1;
        chk("rr_cnt_end", 32'(conflict_cnt), 32'd6);

        // stall hold
        set_req(0, 1'b1, 5'd9, 32'h1234);
        #1;
        chk("stall_load_ready", 32'(req_ready), 32'b001);
        push(5'd9, 32'h1234);
        step();
        set_req(0, 1'b1, 5'd10, 32'h5678);
        port_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_wr_en_%0d", k), 32'(wr_en), 32'h0);
            chk($sformatf("stall_wr_sel_%0d", k), 32'(wr_sel), 32'd9);
            chk($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'h0);
            step();
        end
        port_stall = 1'b0;
        #1;
        chk("unstall_wr_en", 32'(wr_en), 32'h1);
        chk("unstall_ready", 32'(req_ready), 32'b001);
        push(5'd10, 32'h5678);
        step();
        req_valid = '0;
        #1;
        chk("unstall_next_sel", 32'(wr_sel), 32'd10);

        // reset while a stalled write sits in the stage
        set_req(1, 1'b1, 5'd5, 32'h55);
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        port_stall = 1'b1;
        #1;
        chk("rst_mid_hold_wr_en", 32'(wr_en), 32'h0);
        chk("rst_mid_hold_pending", pending_mask, 32'h20);
        reset = 1'b1;
        req_valid = 3'b011;
        #1;
        chk("rst_mid_ready_zero", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
        req_valid = '0;
        port_stall = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'h0);
        chk("rst_mid_pending", pending_mask, 32'h0);
        chk("rst_mid_cnt", 32'(conflict_cnt), 32'h0);

        // counter saturation
        force dut.cnt_q = 16'hFFFE;
        step();
        release dut.cnt_q;
        #1;
        chk("sat_preload", 32'(conflict_cnt), 32'hFFFE);
        set_req(0, 1'b1, 5'd11, 32'hAAAA0000);
        set_req(1, 1'b1, 5'd12, 32'hBBBB0000);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("sat_ready_%0d", k), 32'(req_ready), (k == 1) ? 32'b010 : 32'b001);
            chk($sformatf("sat_cnt_%0d", k), 32'(conflict_cnt), (k == 0) ? 32'hFFFE : 32'hFFFF);
            if (k == 1) push(5'd12, 32'hBBBB0000);
            else push(5'd11, 32'hAAAA0000);
            step();
        end
        req_valid = '0;
        #1;
        chk("sat_cnt_after", 32'(conflict_cnt), 32'hFFFF);
        step();
        step();
        #1;
        chk("sat_cnt_hold", 32'(conflict_cnt), 32'hFFFF);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
